// File: rtl/rv32_pkg.sv
// Shared RV32 constants and the fetch buffer entry type used across the fetch front end.
package rv32_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] RV32_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_ctl_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and memory (slave).
interface fetch_ctl_if;
   import rv32_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] addr;
   logic            rsp_valid;
   logic [ILEN-1:0] rsp_data;

   modport master (output req_valid, addr, input req_ready, rsp_valid, rsp_data);
   modport slave  (input req_valid, addr, output req_ready, rsp_valid, rsp_data);

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with push/pop/flush; flush wins over a same-cycle push/pop.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wptr_q] <= wdata;
   end

   assign rdata = mem_q[rptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_ctl.sv
// Fetch front end: sequential PC, credit-limited imem requests, wrong-path drop, IF/ID output regs.
// Optional: define FETCH_MISALIGN_TRAP_EN to add the fetch_misalign output and trap on misaligned redirects.
module fetch_ctl
   import rv32_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   fetch_ctl_if.master      imem,
   output logic [XLEN-1:0]  pc_if,
   output logic [ILEN-1:0]  instr_if,
   output logic             instr_valid
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic             fetch_misalign
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic            run_q, run_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [XLEN-1:0] pc_if_q, pc_if_d;
   logic [ILEN-1:0] instr_q, instr_d;
   logic            valid_q, valid_d;

   logic            accept, rsp_seen, rsp_keep, credit_ok, trap_hold;
   logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     in_flight;
   logic [XLEN-1:0] target_pc;
   fetch_entry_t    fifo_wdata, fifo_rdata;

   // Words in flight plus words buffered never exceed the buffer size, so a push always fits.
   assign in_flight      = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign credit_ok      = (in_flight < (CW+1)'(FIFO_DEPTH));
   assign target_pc      = align_word(redirect_pc);
   assign imem.req_valid = run_q && !redirect_valid && !trap_hold && credit_ok;
   assign imem.addr      = fetch_pc_q;
   assign accept         = imem.req_valid && imem.req_ready;
   assign rsp_seen       = imem.rsp_valid;
   assign rsp_keep       = rsp_seen && (drop_cnt_q == '0) && !redirect_valid;
   assign fifo_push      = rsp_keep && !fifo_full;
   assign fifo_pop       = !redirect_valid && !stall && !trap_hold && !fifo_empty;
   assign fifo_wdata     = '{pc: rsp_pc_q, instr: imem.rsp_data};

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (redirect_valid),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;

   always_comb begin
      misalign_d = misalign_q;
      if (redirect_valid) misalign_d = (redirect_pc[1:0] != 2'b00);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end

   assign trap_hold      = misalign_q;
   assign fetch_misalign = misalign_q;
`else
   assign trap_hold = 1'b0;
`endif

   always_comb begin
      run_d         = 1'b1;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_seen);
      drop_cnt_d    = drop_cnt_q;
      pc_if_d       = pc_if_q;
      instr_d       = instr_q;
      valid_d       = valid_q;
      if (redirect_valid) begin
         // Everything still in flight after this edge belongs to the abandoned path.
         fetch_pc_d = target_pc;
         rsp_pc_d   = target_pc;
         drop_cnt_d = outstanding_d;
         pc_if_d    = target_pc;
         instr_d    = RV32_NOP;
         valid_d    = 1'b0;
      end else begin
         if (accept)    fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (fifo_push) rsp_pc_d   = rsp_pc_q + XLEN'(4);
         if (rsp_seen && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
         if (!stall) begin
            if (fifo_pop) begin
               pc_if_d = fifo_rdata.pc;
               instr_d = fifo_rdata.instr;
               valid_d = 1'b1;
            end else begin
               instr_d = RV32_NOP;
               valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q         <= 1'b0;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         pc_if_q       <= '0;
         instr_q       <= RV32_NOP;
         valid_q       <= 1'b0;
      end else begin
         run_q         <= run_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         pc_if_q       <= pc_if_d;
         instr_q       <= instr_d;
         valid_q       <= valid_d;
      end
   end

   assign pc_if       = pc_if_q;
   assign instr_if    = instr_q;
   assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_ctl.sv
// Bench for fetch_ctl: reset/latency vector table, then a memory model with program-order scoreboard.
// A second instance with RESET_PC=FFFF_FFF8 checks address wrap; FETCH_MISALIGN_TRAP_EN adds its port.
module tb_fetch_ctl;
   import rv32_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] pc_if, instr_if, b_pc_if, b_instr_if;
   logic        instr_valid, b_instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_misalign, b_fetch_misalign;
`endif

   fetch_ctl_if imem ();
   fetch_ctl_if bmem ();

   always #5 clk = ~clk;

   fetch_ctl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (imem),
      .pc_if          (pc_if),
      .instr_if       (instr_if),
      .instr_valid    (instr_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   fetch_ctl #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_b (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (1'b0),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .imem           (bmem),
      .pc_if          (b_pc_if),
      .instr_if       (b_instr_if),
      .instr_valid    (b_instr_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .fetch_misalign (b_fetch_misalign)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   typedef struct {
      logic        rsp_v;
      logic [31:0] rsp_d;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_breq;
      logic [31:0] e_baddr;
   } vec_t;

   vec_t vecs [9];

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend [$];
   int          cyc_n = 0;
   int          lat = 1;
   logic        st = 1'b0, rv = 1'b0, rdy = 1'b1;
   logic [31:0] rpc = 32'h0;
   logic [31:0] model_next = 32'h0;
   logic [31:0] exp_pc = 32'h0;
   logic        last_req_valid;
   logic [31:0] last_addr;

   // One clock of the memory model plus scoreboard checks of what the edge produced.
   task automatic cyc();
      logic [31:0] pre_pc, pre_instr;
      logic        pre_v, acc;
      @(negedge clk);
      stall = st;
      redirect_valid = rv;
      redirect_pc = rpc;
      imem.req_ready = rdy;
      if (pend.size() != 0 && pend[0].due <= cyc_n) begin
         imem.rsp_valid = 1'b1;
         imem.rsp_data = mem_word(pend[0].addr);
         pend.delete(0);
      end else begin
         imem.rsp_valid = 1'b0;
         imem.rsp_data = 32'h0;
      end
      #1;
      last_req_valid = imem.req_valid;
      last_addr = imem.addr;
      if (rv) check("req_during_redirect", {31'h0, imem.req_valid}, 32'h0);
      else if (imem.req_valid) check("req_addr", imem.addr, model_next);
      acc = imem.req_valid && rdy;
      if (acc) pend.push_back('{addr: imem.addr, due: cyc_n + lat});
      pre_pc = pc_if;
      pre_instr = instr_if;
      pre_v = instr_valid;
      @(posedge clk);
      #1;
      if (rv) begin
         model_next = rpc & ~32'h3;
         exp_pc = rpc & ~32'h3;
         check("redir_pc_if", pc_if, exp_pc);
         check("redir_instr", instr_if, RV32_NOP);
         check("redir_valid", {31'h0, instr_valid}, 32'h0);
      end else begin
         if (acc) model_next = model_next + 32'd4;
         if (st) begin
            check("stall_pc_held", pc_if, pre_pc);
            check("stall_instr_held", instr_if, pre_instr);
            check("stall_valid_held", {31'h0, instr_valid}, {31'h0, pre_v});
         end else if (instr_valid) begin
            check("order_pc", pc_if, exp_pc);
            check("order_instr", instr_if, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end else begin
            check("bubble_nop", instr_if, RV32_NOP);
            check("bubble_pc_held", pc_if, pre_pc);
         end
      end
      cyc_n++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit found;
      imem.req_ready = 1'b1;
      imem.rsp_valid = 1'b0;
      imem.rsp_data  = 32'h0;
      bmem.req_ready = 1'b1;
      bmem.rsp_valid = 1'b0;
      bmem.rsp_data  = 32'h0;

      vecs[0] = '{1'b0, 32'h0,         1'b0, 32'd0,  1'b0, 32'd0,  RV32_NOP,      1'b0, 32'hFFFF_FFF8};
      vecs[1] = '{1'b0, 32'h0,         1'b1, 32'd0,  1'b0, 32'd0,  RV32_NOP,      1'b1, 32'hFFFF_FFF8};
      vecs[2] = '{1'b1, 32'hC0DE_0000, 1'b1, 32'd4,  1'b0, 32'd0,  RV32_NOP,      1'b1, 32'hFFFF_FFFC};
      vecs[3] = '{1'b1, 32'hC0DE_0004, 1'b0, 32'd8,  1'b0, 32'd0,  RV32_NOP,      1'b0, 32'h0000_0000};
      vecs[4] = '{1'b0, 32'h0,         1'b1, 32'd8,  1'b1, 32'd0,  32'hC0DE_0000, 1'b0, 32'h0000_0000};
      vecs[5] = '{1'b1, 32'hC0DE_0008, 1'b1, 32'd12, 1'b1, 32'd4,  32'hC0DE_0004, 1'b0, 32'h0000_0000};
      vecs[6] = '{1'b1, 32'hC0DE_000C, 1'b0, 32'd16, 1'b0, 32'd4,  RV32_NOP,      1'b0, 32'h0000_0000};
      vecs[7] = '{1'b0, 32'h0,         1'b1, 32'd16, 1'b1, 32'd8,  32'hC0DE_0008, 1'b0, 32'h0000_0000};
      vecs[8] = '{1'b0, 32'h0,         1'b1, 32'd20, 1'b1, 32'd12, 32'hC0DE_000C, 1'b0, 32'h0000_0000};

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_valid", {31'h0, imem.req_valid}, 32'h0);
      check("rst_addr", imem.addr, 32'h0);
      check("rst_pc_if", pc_if, 32'h0);
      check("rst_instr", instr_if, RV32_NOP);
      check("rst_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_b_addr", bmem.addr, 32'hFFFF_FFF8);
      check("rst_b_out", {b_pc_if[30:0], b_instr_valid}, 32'h0);
      check("rst_b_instr", b_instr_if, RV32_NOP);

      // Release, 1-cycle responses, address wrap on the second instance
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         imem.rsp_valid = vecs[i].rsp_v;
         imem.rsp_data  = vecs[i].rsp_d;
         #1;
         check($sformatf("row%0d_req_valid", i), {31'h0, imem.req_valid}, {31'h0, vecs[i].e_req});
         check($sformatf("row%0d_addr", i), imem.addr, vecs[i].e_addr);
         check($sformatf("row%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].e_iv});
         check($sformatf("row%0d_pc_if", i), pc_if, vecs[i].e_pc);
         check($sformatf("row%0d_instr", i), instr_if, vecs[i].e_instr);
         check($sformatf("row%0d_b_req", i), {31'h0, bmem.req_valid}, {31'h0, vecs[i].e_breq});
         check($sformatf("row%0d_b_addr", i), bmem.addr, vecs[i].e_baddr);
      end

      // Asynchronous reset mid-stream with a request outstanding
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_req_valid", {31'h0, imem.req_valid}, 32'h0);
      check("async_rst_addr", imem.addr, 32'h0);
      check("async_rst_pc_if", pc_if, 32'h0);
      check("async_rst_instr", instr_if, RV32_NOP);
      check("async_rst_valid", {31'h0, instr_valid}, 32'h0);
      imem.rsp_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      pend.delete();
      model_next = 32'h0;
      exp_pc = 32'h0;

      // Streaming warm-up
      lat = 1; st = 1'b0; rv = 1'b0; rdy = 1'b1;
      repeat (10) cyc();

      // Stall with the buffer filling up: requests stop, nothing lost or duplicated afterwards
      st = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (i >= 3) check("stall_full_no_req", {31'h0, last_req_valid}, 32'h0);
      end
      st = 1'b0;
      repeat (8) cyc();

      // Redirect with two responses outstanding
      lat = 3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cyc();
         if (pend.size() == 2) found = 1'b1;
      end
      check("two_outstanding_reached", {31'h0, found}, 32'h1);
      rv = 1'b1; rpc = 32'h0000_0100;
      cyc();
      rv = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cyc();
         if (instr_valid) found = 1'b1;
      end
      check("redirect_valid_seen", {31'h0, found}, 32'h1);
      check("redirect_first_pc", pc_if, 32'h0000_0100);
      repeat (6) cyc();

      // Memory not ready: address held; redirect mid-wait moves it to the target
      lat = 1; rdy = 1'b0;
      repeat (6) cyc();
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("wait_req_held", {31'h0, last_req_valid}, 32'h1);
      end
      rv = 1'b1; rpc = 32'h0000_0240;
      cyc();
      rv = 1'b0;
      cyc();
      check("wait_redirect_addr", last_addr, 32'h0000_0240);
      check("wait_redirect_req", {31'h0, last_req_valid}, 32'h1);
      rdy = 1'b1;
      repeat (8) cyc();

`ifndef FETCH_MISALIGN_TRAP_EN
      // Low redirect bits are cleared when the trap is not built in
      rv = 1'b1; rpc = 32'h0000_0306;
      cyc();
      rv = 1'b0;
      check("misaligned_cleared_pc", pc_if, 32'h0000_0304);
      repeat (8) cyc();
`endif

      // Back-to-back redirects with responses in flight
      lat = 2;
      repeat (4) cyc();
      rv = 1'b1; rpc = 32'h0000_0400;
      cyc();
      rpc = 32'h0000_0500;
      cyc();
      rv = 1'b0;
      repeat (12) cyc();
      check("b2b_progress", {31'h0, exp_pc > 32'h0000_0500}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
